// File: rtl/writeback_unit_pkg.sv
// ---------------------------------------------------------------------------
// writeback_unit_pkg
// Shared widths and constants for the write-back stage.
//   XLEN      : data width of ALU results and load data
//   REG_AW    : register-number width
//   DEPTH_DEF : default number of outstanding loads tracked
//   ZERO_REG  : hard-wired zero register; writes to it are dropped
// wb_req_t is one candidate write to the register bank.
// ---------------------------------------------------------------------------
package writeback_unit_pkg;
  localparam int XLEN      = 32;
  localparam int REG_AW    = 5;
  localparam int DEPTH_DEF = 4;
  localparam logic [REG_AW-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dest;
    logic [XLEN-1:0]   data;
  } wb_req_t;
endpackage

// File: rtl/writeback_unit_dest_fifo.sv
// ---------------------------------------------------------------------------
// dest_fifo
// In-order FIFO of load destination registers.
//   clk, reset       : clock, synchronous active-low reset
//   i_push, i_push_data : record a destination (ignored when full)
//   i_pop            : drop the head entry (ignored when empty)
//   o_head           : destination at the head
//   o_full, o_empty  : occupancy flags from the registered count
//   o_ent_valid      : one bit per storage slot, set if the slot is live
//   o_ent_data       : all slots flattened, slot i at [i*REG_AW +: REG_AW]
// ---------------------------------------------------------------------------
module dest_fifo
  import writeback_unit_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_push,
  input  logic [REG_AW-1:0]       i_push_data,
  input  logic                    i_pop,
  output logic [REG_AW-1:0]       o_head,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [DEPTH-1:0]        o_ent_valid,
  output logic [DEPTH*REG_AW-1:0] o_ent_data
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [PW:0]       r_count;
  logic [REG_AW-1:0] r_mem [DEPTH];

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: liveness comes from the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  // A slot is live when its distance from the read pointer (mod DEPTH)
  // is below the count; this also covers the full case.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    logic [PW-1:0] w_off;
    assign w_off                              = PW'(gi) - r_rd_ptr;
    assign o_ent_valid[gi]                    = ({1'b0, w_off} < r_count);
    assign o_ent_data[gi*REG_AW +: REG_AW]    = r_mem[gi];
  end
endmodule

// File: rtl/writeback_unit.sv
// ---------------------------------------------------------------------------
// writeback_unit
// Merges ALU results and in-order load responses onto the single register
// bank write port, with a one-entry hold register for responses that lose
// arbitration, a pending scoreboard driving the load-use stall, and a sticky
// protocol-error flag.
//   clk, reset            : clock, synchronous active-low reset
//   alu_valid/dest/data   : ALU result (never back-pressured)
//   ld_req/ld_dest        : load issue; recorded when ld_ready
//   ld_ready              : destination FIFO not full
//   mem_valid/mem_data    : load response; taken when mem_ready
//   mem_ready             : hold register empty
//   src_a, src_b, stall   : decode sources and load-use stall
//   RegEscr/EscrReg/DatoEscr : registered bank write port
//   err                   : sticky protocol error
// Handshake: a load is recorded on an edge where ld_req && ld_ready; a
// response is consumed on an edge where mem_valid && mem_ready and the FIFO
// is non-empty. ld_ready/mem_ready depend only on registered state.
// ---------------------------------------------------------------------------
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_dest,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              ld_req,
  input  logic [REG_AW-1:0] ld_dest,
  output logic              ld_ready,
  input  logic              mem_valid,
  input  logic [XLEN-1:0]   mem_data,
  output logic              mem_ready,
  input  logic [REG_AW-1:0] src_a,
  input  logic [REG_AW-1:0] src_b,
  output logic              stall,
  output logic [REG_AW-1:0] RegEscr,
  output logic              EscrReg,
  output logic [XLEN-1:0]   DatoEscr,
  output logic              err
);
  logic                    w_fifo_full;
  logic                    w_fifo_empty;
  logic [REG_AW-1:0]       w_head;
  logic [DEPTH-1:0]        w_ent_valid;
  logic [DEPTH*REG_AW-1:0] w_ent_data;

  logic                    w_push;
  logic                    w_accept;
  logic [31:0]             w_pending;
  wb_req_t                 w_win;
  logic                    w_to_hold;
  logic                    w_wen;
  logic                    w_err_evt;

  wb_req_t                 r_hold;

  dest_fifo #(.DEPTH(DEPTH)) u_dest_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (ld_dest),
    .i_pop       (w_accept),
    .o_head      (w_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_ent_valid (w_ent_valid),
    .o_ent_data  (w_ent_data)
  );

  assign ld_ready  = ~w_fifo_full;
  assign mem_ready = ~r_hold.valid;
  assign w_push    = ld_req & ld_ready;
  // A response with nothing outstanding is flagged and otherwise dropped.
  assign w_accept  = mem_valid & mem_ready & ~w_fifo_empty;

  // Pending set: every live FIFO destination plus the held one, minus r0.
  always_comb begin
    w_pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_ent_valid[i]) w_pending[w_ent_data[i*REG_AW +: REG_AW]] = 1'b1;
    end
    if (r_hold.valid) w_pending[r_hold.dest] = 1'b1;
    w_pending[0] = 1'b0;
  end

  assign stall = w_pending[src_a] | w_pending[src_b];

  // Priority: ALU, then hold, then the fresh response. Hold and a fresh
  // response never compete, since accepting requires an empty hold.
  always_comb begin
    w_win     = '0;
    w_to_hold = 1'b0;
    if (alu_valid) begin
      w_win     = '{valid: 1'b1, dest: alu_dest, data: alu_data};
      w_to_hold = w_accept;
    end else if (r_hold.valid) begin
      w_win = r_hold;
    end else if (w_accept) begin
      w_win = '{valid: 1'b1, dest: w_head, data: mem_data};
    end
  end

  assign w_wen     = w_win.valid & (w_win.dest != ZERO_REG);
  assign w_err_evt = (mem_valid & w_fifo_empty) | (alu_valid & w_pending[alu_dest]);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hold   <= '0;
      RegEscr  <= '0;
      EscrReg  <= 1'b0;
      DatoEscr <= '0;
      err      <= 1'b0;
    end else begin
      if (w_to_hold) begin
        r_hold <= '{valid: 1'b1, dest: w_head, data: mem_data};
      end else if (!alu_valid && r_hold.valid) begin
        r_hold.valid <= 1'b0;
      end
      EscrReg  <= w_wen;
      RegEscr  <= w_wen ? w_win.dest : ZERO_REG;
      DatoEscr <= w_wen ? w_win.data : '0;
      err      <= err | w_err_evt;
    end
  end
endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_dest;
  logic [31:0] alu_data;
  logic        ld_req;
  logic [4:0]  ld_dest;
  logic        ld_ready;
  logic        mem_valid;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic [4:0]  src_a, src_b;
  logic        stall;
  logic [4:0]  RegEscr;
  logic        EscrReg;
  logic [31:0] DatoEscr;
  logic        err;

  writeback_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data),
    .ld_req(ld_req), .ld_dest(ld_dest), .ld_ready(ld_ready),
    .mem_valid(mem_valid), .mem_data(mem_data), .mem_ready(mem_ready),
    .src_a(src_a), .src_b(src_b), .stall(stall),
    .RegEscr(RegEscr), .EscrReg(EscrReg), .DatoEscr(DatoEscr), .err(err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [4:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Outstanding loads as a plain queue of destinations; hold as a flag+data.
  int          m_q[$];
  bit          m_hv = 0;
  logic [4:0]  m_hd = '0;
  logic [31:0] m_hx = '0;
  logic        m_wen = 0;
  logic [4:0]  m_reg = '0;
  logic [31:0] m_dat = '0;
  logic        m_err = 0;

  function automatic bit pend(input logic [4:0] r);
    if (r == 0) return 0;
    if (m_hv && m_hd == r) return 1;
    foreach (m_q[i]) if (m_q[i] == int'(r)) return 1;
    return 0;
  endfunction

  task automatic model_step();
    bit acc, wv;
    logic [4:0] rd, wd;
    logic [31:0] rx, wx;
    int sz;
    if (!reset) begin
      m_q.delete();
      m_hv = 0; m_hd = '0; m_hx = '0;
      m_wen = 0; m_reg = '0; m_dat = '0; m_err = 0;
      return;
    end
    sz = m_q.size();
    if ((mem_valid && sz == 0) || (alu_valid && pend(alu_dest))) m_err = 1;
    acc = mem_valid && !m_hv && sz > 0;
    rd = '0; rx = '0;
    if (acc) begin
      rd = 5'(m_q.pop_front());
      rx = mem_data;
    end
    if (ld_req && sz < DEPTH) m_q.push_back(int'(ld_dest));
    wv = 0; wd = '0; wx = '0;
    if (alu_valid) begin
      wv = 1; wd = alu_dest; wx = alu_data;
      if (acc) begin m_hv = 1; m_hd = rd; m_hx = rx; end
    end else if (m_hv) begin
      wv = 1; wd = m_hd; wx = m_hx; m_hv = 0;
    end else if (acc) begin
      wv = 1; wd = rd; wx = rx;
    end
    m_wen = wv && (wd != 0);
    m_reg = m_wen ? wd : 5'd0;
    m_dat = m_wen ? wx : 32'd0;
  endtask

  // ---------------- driver ----------------
  bit   chk_pre = 0;
  logic a_ldr, a_mr, a_st;

  task automatic idle();
    alu_valid = 0; alu_dest = '0; alu_data = '0;
    ld_req = 0; ld_dest = '0; mem_valid = 0; mem_data = '0;
    src_a = '0; src_b = '0;
  endtask

  // Called just after a negedge with inputs set. Checks the combinational
  // outputs for this cycle, then the registered outputs after the edge.
  task automatic tick();
    #1;
    a_ldr = ld_ready; a_mr = mem_ready; a_st = stall;
    if (chk_pre && reset) begin
      chk("ld_ready", ld_ready, 32'(m_q.size() < DEPTH));
      chk("mem_ready", mem_ready, 32'(!m_hv));
      chk("stall", stall, 32'(pend(src_a) | pend(src_b)));
    end
    model_step();
    @(posedge clk);
    #1;
    chk("EscrReg", EscrReg, 32'(m_wen));
    chk("RegEscr", RegEscr, 32'(m_reg));
    chk("DatoEscr", DatoEscr, m_dat);
    chk("err", err, 32'(m_err));
    @(negedge clk);
  endtask

  // ---------------- directed vector table ----------------
  // Inputs of row k are applied in cycle k; e_ldr/e_mr/e_st are expected
  // during cycle k, e_wen/e_reg/e_dat/e_err right after its rising edge.
  typedef struct {
    logic rst_n; logic alu_v; logic [4:0] alu_d; logic [31:0] alu_x;
    logic ld; logic [4:0] ld_d; logic mv; logic [31:0] mx;
    logic [4:0] sa, sb;
    logic e_ldr, e_mr, e_st;
    logic e_wen; logic [4:0] e_reg; logic [31:0] e_dat; logic e_err;
  } vec_t;

  function automatic vec_t mk(
      input logic rst_n, input logic alu_v, input logic [4:0] alu_d, input logic [31:0] alu_x,
      input logic ld, input logic [4:0] ld_d, input logic mv, input logic [31:0] mx,
      input logic [4:0] sa, input logic [4:0] sb,
      input logic e_ldr, input logic e_mr, input logic e_st,
      input logic e_wen, input logic [4:0] e_reg, input logic [31:0] e_dat, input logic e_err);
    vec_t v;
    v.rst_n = rst_n; v.alu_v = alu_v; v.alu_d = alu_d; v.alu_x = alu_x;
    v.ld = ld; v.ld_d = ld_d; v.mv = mv; v.mx = mx; v.sa = sa; v.sb = sb;
    v.e_ldr = e_ldr; v.e_mr = e_mr; v.e_st = e_st;
    v.e_wen = e_wen; v.e_reg = e_reg; v.e_dat = e_dat; v.e_err = e_err;
    return v;
  endfunction

  vec_t vecs[15];

  initial begin
    //             rst alu d   data        ld d  mv data        sa sb  ldr mr st  wen reg data      err
    vecs[0]  = mk(1, 1, 5, 32'h1234,   0, 0, 0, 32'h0,    0, 0,  1, 1, 0,  1, 5, 32'h1234, 0);
    vecs[1]  = mk(1, 0, 0, 32'h0,      0, 0, 0, 32'h0,    0, 0,  1, 1, 0,  0, 0, 32'h0,    0);
    vecs[2]  = mk(1, 0, 0, 32'h0,      1, 7, 0, 32'h0,    0, 0,  1, 1, 0,  0, 0, 32'h0,    0);
    vecs[3]  = mk(1, 0, 0, 32'h0,      0, 0, 0, 32'h0,    7, 0,  1, 1, 1,  0, 0, 32'h0,    0);
    vecs[4]  = mk(1, 0, 0, 32'h0,      0, 0, 1, 32'hCAFE, 7, 0,  1, 1, 1,  1, 7, 32'hCAFE, 0);
    vecs[5]  = mk(1, 0, 0, 32'h0,      0, 0, 0, 32'h0,    7, 0,  1, 1, 0,  0, 0, 32'h0,    0);
    vecs[6]  = mk(1, 0, 0, 32'h0,      1, 9, 0, 32'h0,    0, 0,  1, 1, 0,  0, 0, 32'h0,    0);
    vecs[7]  = mk(1, 1, 3, 32'h33,     0, 0, 1, 32'hAA,   0, 9,  1, 1, 1,  1, 3, 32'h33,   0);
    vecs[8]  = mk(1, 0, 0, 32'h0,      0, 0, 0, 32'h0,    0, 9,  1, 0, 1,  1, 9, 32'hAA,   0);
    vecs[9]  = mk(1, 0, 0, 32'h0,      0, 0, 0, 32'h0,    0, 9,  1, 1, 0,  0, 0, 32'h0,    0);
    vecs[10] = mk(1, 0, 0, 32'h0,      1, 0, 0, 32'h0,    0, 0,  1, 1, 0,  0, 0, 32'h0,    0);
    vecs[11] = mk(1, 0, 0, 32'h0,      0, 0, 1, 32'hFF,   0, 0,  1, 1, 0,  0, 0, 32'h0,    0);
    vecs[12] = mk(1, 0, 0, 32'h0,      0, 0, 1, 32'h77,   0, 0,  1, 1, 0,  0, 0, 32'h0,    1);
    vecs[13] = mk(1, 0, 0, 32'h0,      0, 0, 0, 32'h0,    0, 0,  1, 1, 0,  0, 0, 32'h0,    1);
    vecs[14] = mk(0, 0, 0, 32'h0,      0, 0, 0, 32'h0,    0, 0,  1, 1, 0,  0, 0, 32'h0,    0);
  end

  // ---------------- test sequence ----------------
  initial begin
    idle();
    reset = 0;
    @(negedge clk);
    tick();
    tick();
    chk_pre = 1;
    reset = 1;

    // reset state
    #1;
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_mem_ready", mem_ready, 1);
    chk("rst_stall", stall, 0);
    chk("rst_EscrReg", EscrReg, 0);
    chk("rst_RegEscr", RegEscr, 0);
    chk("rst_DatoEscr", DatoEscr, 0);
    chk("rst_err", err, 0);
    @(negedge clk);

    // table-driven directed vectors
    for (int k = 0; k < 15; k++) begin
      reset = vecs[k].rst_n;
      alu_valid = vecs[k].alu_v; alu_dest = vecs[k].alu_d; alu_data = vecs[k].alu_x;
      ld_req = vecs[k].ld; ld_dest = vecs[k].ld_d;
      mem_valid = vecs[k].mv; mem_data = vecs[k].mx;
      src_a = vecs[k].sa; src_b = vecs[k].sb;
      tick();
      chk($sformatf("v%0d_ld_ready", k), a_ldr, vecs[k].e_ldr);
      chk($sformatf("v%0d_mem_ready", k), a_mr, vecs[k].e_mr);
      chk($sformatf("v%0d_stall", k), a_st, vecs[k].e_st);
      chk($sformatf("v%0d_EscrReg", k), EscrReg, vecs[k].e_wen);
      chk($sformatf("v%0d_RegEscr", k), RegEscr, vecs[k].e_reg);
      chk($sformatf("v%0d_DatoEscr", k), DatoEscr, vecs[k].e_dat);
      chk($sformatf("v%0d_err", k), err, vecs[k].e_err);
    end
    reset = 1;
    idle();

    // FIFO full, ignored fifth load, in-order writes, pointer wrap.
    // One load/response first so the pointers start off zero.
    ld_req = 1; ld_dest = 5'd1; tick();
    idle(); mem_valid = 1; mem_data = 32'h1; tick();
    idle(); tick();
    for (int rnd = 0; rnd < 2; rnd++) begin
      for (int k = 0; k < 5; k++) begin
        idle();
        ld_req = 1; ld_dest = 5'(10 + rnd*10 + k);
        tick();
        if (k < 4) exp_q.push_back(5'(10 + rnd*10 + k));
        else chk($sformatf("r%0d_fifth_ld_ready", rnd), a_ldr, 0);
      end
      for (int k = 0; k < 4; k++) begin
        idle();
        mem_valid = 1; mem_data = 32'(100 + k);
        tick();
        if (EscrReg === 1'b1) begin
          if (exp_q.size() == 0) chk("order_unexpected_write", RegEscr, 0);
          else chk($sformatf("r%0d_order_%0d", rnd, k), RegEscr, exp_q.pop_front());
        end
      end
      idle(); tick();
      chk($sformatf("r%0d_order_drained", rnd), 32'(exp_q.size()), 0);
    end

    // Reset with two loads outstanding; later response is an error.
    ld_req = 1; ld_dest = 5'd4; tick();
    ld_dest = 5'd6; tick();
    idle(); src_a = 5'd4; tick();
    chk("mid_stall_before", a_st, 1);
    reset = 0; tick();
    reset = 1;
    chk("mid_rst_EscrReg", EscrReg, 0);
    chk("mid_rst_RegEscr", RegEscr, 0);
    chk("mid_rst_err", err, 0);
    mem_valid = 1; mem_data = 32'h55; tick();
    chk("mid_ld_ready_after", a_ldr, 1);
    chk("mid_stall_after", a_st, 0);
    chk("mid_err_late_resp", err, 1);
    idle(); tick();
    chk("mid_err_sticky", err, 1);

    // Randomized traffic checked against the model.
    reset = 0; tick(); reset = 1;
    for (int c = 0; c < 800; c++) begin
      idle();
      reset     = ($urandom_range(0, 99) != 0);
      alu_valid = ($urandom_range(0, 9) < 4);
      alu_dest  = 5'($urandom_range(0, 7));
      alu_data  = $urandom;
      ld_req    = ($urandom_range(0, 9) < 4);
      ld_dest   = 5'($urandom_range(0, 7));
      mem_valid = (m_q.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 49) == 0);
      mem_data  = $urandom;
      src_a     = 5'($urandom_range(0, 7));
      src_b     = 5'($urandom_range(0, 7));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
